multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports opcode and funct, inputs, 6 bits each: fields of the instruction register.
REQ-004 SHALL have port zero, input, 1 bit: crs == alu_input comparator result.
REQ-005 SHALL have port mem_ready, input, 1 bit: unified memory completes the current request this cycle.
REQ-006 SHALL have strobe outputs pc_wr, ir_wr, rf_wr, mem_req, mem_we, 1 bit each: PC load, IR load, register write, memory request, memory write.
REQ-007 SHALL have port iord, output, 1 bit: memory address source, 0 = pc, 1 = alu_output.
REQ-008 SHALL have datapath select outputs: seu_en and alu_src_b (1 bit each); alu_op (4 bits); dw_sel, rw_sel and next_pc_sel (2 bits each); encodings identical to the single-cycle datapath.
REQ-009 SHALL have port state, output, 3 bits (current FSM state), and port illegal, output, 1 bit (one-cycle pulse on an undecodable instruction).

Function
REQ-010 SHALL implement registered states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; outputs decode combinationally from state, opcode, funct and zero.
REQ-011 FETCH: mem_req=1, iord=0; hold until mem_ready=1, then ir_wr=1 in that cycle -> DECODE; mem_ready=0 -> stay FETCH, ir_wr=0.
REQ-012 DECODE, J (000010): pc_wr=1, next_pc_sel=10 -> FETCH.
REQ-013 DECODE, JR (R-type, funct 001000): pc_wr=1, next_pc_sel=11 -> FETCH.
REQ-014 DECODE, JAL (000011): rf_wr=1, dw_sel=01, rw_sel=10 (register 31), pc_wr=1, next_pc_sel=10 -> FETCH.
REQ-015 DECODE, unsupported opcode/funct: illegal=1, pc_wr=1, next_pc_sel=00 -> FETCH (skip); otherwise -> EXEC.
REQ-016 EXEC: drive alu_op/alu_src_b for the instruction. R-type and ADDI/ADDIU/ANDI/ORI/SLTI/SLTIU -> WB. LW (100011)/SW (101011) -> MEM. BEQ/BNE: pc_wr=1, next_pc_sel=01 if taken (BEQ zero=1, BNE zero=0), else 00 -> FETCH.
REQ-017 alu_op mapping SHALL be: add/addu/addi/addiu/lw/sw 0000; sub/subu 0001; and/andi 0010; or/ori 0011; sll 0100; srl 0101; slt/sltu/slti/sltiu 1000. alu_src_b=1 for I-type; seu_en=1 only for ADDI, SLTI, LW, SW, BEQ, BNE.
REQ-018 MEM: mem_req=1, iord=1, mem_we=1 for SW only; alu_op/alu_src_b held as in EXEC; wait for mem_ready. On ready, SW: pc_wr=1, next_pc_sel=00 -> FETCH; LW -> WB.
REQ-019 WB: rf_wr=1; dw_sel=10 for LW, else 00; rw_sel=00 for R-type, else 01; pc_wr=1, next_pc_sel=00 -> FETCH.
REQ-020 Zero-wait cycle counts SHALL be: J/JR/JAL 2, branch 3, R/I-type ALU 4, SW 4, LW 5; each mem_ready=0 cycle adds exactly one.
REQ-021 mem_req SHALL remain asserted with stable iord/mem_we until the mem_ready cycle; mem_ready outside FETCH/MEM SHALL be ignored.
REQ-022 Every strobe SHALL be 0 in any state/condition not listed above; pc_wr SHALL assert exactly once per instruction.

Reset
REQ-023 rst=1 SHALL force state=FETCH immediately and all outputs to 0 (including mem_req) while asserted, regardless of clk.
REQ-024 Reset mid-MEM or mid-FETCH SHALL abort the access with no ir_wr, rf_wr or pc_wr; the first FETCH request SHALL follow the first rising clk after rst deasserts.

Configuration
REQ-025 With INSTR_COUNT_EN defined: output retired, 32 bits, reset 0, +1 on every pc_wr cycle (illegal skips included), wrapping 0xFFFFFFFF -> 0; without it the port and counter SHALL be absent.

Structure
REQ-026 Package multicycle_pkg SHALL hold the state encoding, opcode/funct constants and alu_op codes.
REQ-027 Sub-module alu_op_decoder (combinational opcode/funct -> alu_op, alu_src_b, seu_en) SHALL be instantiated once.

Verification
REQ-028 ADD (op 000000, funct 100000), mem_ready=1 throughout -> states 0,1,2,4; rf_wr=1 and pc_wr=1 in cycle 4 only.
REQ-029 LW with mem_ready low for 2 cycles in MEM -> 7 cycles; mem_req=1, iord=1 for 3 MEM cycles; WB dw_sel=10, rw_sel=01.
REQ-030 BEQ zero=1 -> next_pc_sel=01 in EXEC; BNE zero=1 -> next_pc_sel=00; both pc_wr=1, 3 cycles.
REQ-031 JAL -> DECODE rf_wr=1, dw_sel=01, rw_sel=10, next_pc_sel=10, 2 cycles; opcode 111111 -> illegal=1 pulse, next_pc_sel=00.
REQ-032 rst pulsed mid-MEM of SW -> mem_req/mem_we drop same cycle, state=0, no pc_wr; retired (INSTR_COUNT_EN) reads 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// MIPS opcode/funct field values, ALU operation codes and datapath select
// encodings, plus the instruction-legality helper.
package multicycle_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // opcode field
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // funct field (R-type)
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;

   // alu_op codes
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SLT = 4'b1000;

   // next_pc_sel / dw_sel / rw_sel encodings
   localparam logic [1:0] NPC_SEQ    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_REG    = 2'b11;
   localparam logic [1:0] DW_ALU     = 2'b00;
   localparam logic [1:0] DW_PC      = 2'b01;
   localparam logic [1:0] DW_MEM     = 2'b10;
   localparam logic [1:0] RW_RD      = 2'b00;
   localparam logic [1:0] RW_RT      = 2'b01;
   localparam logic [1:0] RW_RA      = 2'b10;

   function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE:
            case (fn)
               F_SLL, F_SRL, F_JR, F_ADD, F_ADDU, F_SUB, F_SUBU,
               F_AND, F_OR, F_SLT, F_SLTU: ok = 1'b1;
               default:                    ok = 1'b0;
            endcase
         OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
         OP_SLTIU, OP_ANDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// alu_op_decoder: combinational opcode/funct -> ALU controls.
//   opcode, funct : instruction register fields
//   alu_op        : ALU operation code
//   alu_src_b     : 1 = immediate operand
//   seu_en        : 1 = sign-extend the immediate
module alu_op_decoder
   import multicycle_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       alu_src_b,
   output logic       seu_en
);

   always_comb begin
      alu_op    = ALU_ADD;
      alu_src_b = 1'b0;
      seu_en    = 1'b0;
      case (opcode)
         OP_RTYPE:
            case (funct)
               F_SUB, F_SUBU: alu_op = ALU_SUB;
               F_AND:         alu_op = ALU_AND;
               F_OR:          alu_op = ALU_OR;
               F_SLL:         alu_op = ALU_SLL;
               F_SRL:         alu_op = ALU_SRL;
               F_SLT, F_SLTU: alu_op = ALU_SLT;
               default:       alu_op = ALU_ADD;
            endcase
         OP_ADDI:  begin alu_src_b = 1'b1; seu_en = 1'b1; end
         OP_ADDIU: alu_src_b = 1'b1;
         OP_ANDI:  begin alu_op = ALU_AND; alu_src_b = 1'b1; end
         OP_ORI:   begin alu_op = ALU_OR;  alu_src_b = 1'b1; end
         OP_SLTI:  begin alu_op = ALU_SLT; alu_src_b = 1'b1; seu_en = 1'b1; end
         OP_SLTIU: begin alu_op = ALU_SLT; alu_src_b = 1'b1; end
         OP_LW, OP_SW: begin alu_src_b = 1'b1; seu_en = 1'b1; end
         // branches compare two registers; the immediate is the offset
         OP_BEQ, OP_BNE: seu_en = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving
// a unified-memory datapath. Outputs decode combinationally from the state
// register and the IR fields.
//   clk, rst (async, active high)
//   opcode, funct, zero, mem_ready : inputs
//   pc_wr, ir_wr, rf_wr, mem_req, mem_we, iord : strobes / address select
//   seu_en, alu_src_b, alu_op, dw_sel, rw_sel, next_pc_sel : datapath selects
//   state, illegal : FSM state and undecodable-instruction pulse
// Optional: define INSTR_COUNT_EN to add the 32-bit retired-instruction
// counter output "retired".
module multicycle_control_unit
   import multicycle_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_wr,
   output logic        ir_wr,
   output logic        rf_wr,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        seu_en,
   output logic        alu_src_b,
   output logic [3:0]  alu_op,
   output logic [1:0]  dw_sel,
   output logic [1:0]  rw_sel,
   output logic [1:0]  next_pc_sel,
   output logic [2:0]  state,
   output logic        illegal
`ifdef INSTR_COUNT_EN
   ,
   output logic [31:0] retired
`endif
);

   state_t     state_q, state_d;
   logic       run_q;
   logic [3:0] dec_alu_op;
   logic       dec_alu_src_b, dec_seu_en;
   logic       legal, is_rtype, is_lw, is_sw, is_beq, is_bne;

   alu_op_decoder u_alu_op_decoder (
      .opcode    (opcode),
      .funct     (funct),
      .alu_op    (dec_alu_op),
      .alu_src_b (dec_alu_src_b),
      .seu_en    (dec_seu_en)
   );

   assign legal    = instr_legal(opcode, funct);
   assign is_rtype = (opcode == OP_RTYPE);
   assign is_lw    = (opcode == OP_LW);
   assign is_sw    = (opcode == OP_SW);
   assign is_beq   = (opcode == OP_BEQ);
   assign is_bne   = (opcode == OP_BNE);
   assign state    = state_q;

   // run_q clears asynchronously with rst and sets on the first rising clk
   // after release, so every output is 0 during reset and the first memory
   // request starts only after that edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_wr       = 1'b0;
      ir_wr       = 1'b0;
      rf_wr       = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      seu_en      = 1'b0;
      alu_src_b   = 1'b0;
      alu_op      = '0;
      dw_sel      = '0;
      rw_sel      = '0;
      next_pc_sel = '0;
      illegal     = 1'b0;
      if (run_q) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_wr   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               state_d = S_FETCH;
               if (!legal) begin
                  illegal     = 1'b1;
                  pc_wr       = 1'b1;
                  next_pc_sel = NPC_SEQ;
               end else if (opcode == OP_J) begin
                  pc_wr       = 1'b1;
                  next_pc_sel = NPC_JUMP;
               end else if (is_rtype && funct == F_JR) begin
                  pc_wr       = 1'b1;
                  next_pc_sel = NPC_REG;
               end else if (opcode == OP_JAL) begin
                  rf_wr       = 1'b1;
                  dw_sel      = DW_PC;
                  rw_sel      = RW_RA;
                  pc_wr       = 1'b1;
                  next_pc_sel = NPC_JUMP;
               end else begin
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               alu_op    = dec_alu_op;
               alu_src_b = dec_alu_src_b;
               seu_en    = dec_seu_en;
               if (is_lw || is_sw) begin
                  state_d = S_MEM;
               end else if (is_beq || is_bne) begin
                  pc_wr       = 1'b1;
                  next_pc_sel = ((is_beq && zero) || (is_bne && !zero)) ? NPC_BRANCH : NPC_SEQ;
                  state_d     = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
            S_MEM: begin
               alu_op    = dec_alu_op;
               alu_src_b = dec_alu_src_b;
               seu_en    = dec_seu_en;
               mem_req   = 1'b1;
               iord      = 1'b1;
               mem_we    = is_sw;
               if (mem_ready) begin
                  if (is_sw) begin
                     pc_wr       = 1'b1;
                     next_pc_sel = NPC_SEQ;
                     state_d     = S_FETCH;
                  end else begin
                     state_d = S_WB;
                  end
               end
            end
            S_WB: begin
               rf_wr       = 1'b1;
               dw_sel      = is_lw ? DW_MEM : DW_ALU;
               rw_sel      = is_rtype ? RW_RD : RW_RT;
               pc_wr       = 1'b1;
               next_pc_sel = NPC_SEQ;
               state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

`ifdef INSTR_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         retired <= '0;
      else if (pc_wr)
         retired <= retired + 32'd1;
   end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, reset-abort
// sequences and randomized instruction streams against a per-instruction
// cycle-list model.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode, funct;
   logic        zero, mem_ready;
   logic        pc_wr, ir_wr, rf_wr, mem_req, mem_we, iord, seu_en, alu_src_b;
   logic [3:0]  alu_op;
   logic [1:0]  dw_sel, rw_sel, next_pc_sel;
   logic [2:0]  state;
   logic        illegal;
`ifdef INSTR_COUNT_EN
   logic [31:0] retired;
`endif

   int checks = 0;
   int errors = 0;
   int exp_retired = 0;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .rf_wr(rf_wr),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .seu_en(seu_en),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .dw_sel(dw_sel), .rw_sel(rw_sel),
      .next_pc_sel(next_pc_sel), .state(state), .illegal(illegal)
`ifdef INSTR_COUNT_EN
      , .retired(retired)
`endif
   );

   typedef struct packed {
      logic [2:0] state;
      logic       pc_wr, ir_wr, rf_wr, mem_req, mem_we, iord, seu_en, alu_src_b;
      logic [3:0] alu_op;
      logic [1:0] dw_sel, rw_sel, next_pc_sel;
      logic       illegal;
   } obs_t;

   typedef enum int {CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JR, CL_JAL, CL_ILL} cls_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      cls_t       cls;
      logic [3:0] alu;
      logic       srcb;
      logic       seu;
   } info_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         fw;
      int         mw;
      int         cyc;
      logic [1:0] nps;
      logic       ill;
      logic [3:0] alu;
   } vec_t;

   info_t itab[23];
   vec_t  vt[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.state = state; o.pc_wr = pc_wr; o.ir_wr = ir_wr; o.rf_wr = rf_wr;
      o.mem_req = mem_req; o.mem_we = mem_we; o.iord = iord; o.seu_en = seu_en;
      o.alu_src_b = alu_src_b; o.alu_op = alu_op; o.dw_sel = dw_sel;
      o.rw_sel = rw_sel; o.next_pc_sel = next_pc_sel; o.illegal = illegal;
      return o;
   endfunction

   function automatic info_t lookup(input logic [5:0] op, input logic [5:0] fn);
      info_t r;
      r.op = op; r.fn = fn; r.cls = CL_ILL; r.alu = 4'b0000; r.srcb = 1'b0; r.seu = 1'b0;
      foreach (itab[i])
         if (itab[i].op == op && (op != 6'd0 || itab[i].fn == fn)) r = itab[i];
      return r;
   endfunction

   // Builds the expected per-cycle output list for one instruction, drives it
   // and compares every cycle; returns what the DUT did at its pc_wr.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw,
                            output int first_pc, output int n_pc, output logic [1:0] pc_nps,
                            output logic saw_ill, output logic [3:0] ex_alu);
      info_t inf;
      obs_t  e, a;
      obs_t  exp_q[$];
      logic  rdy_q[$];
      logic  ex_only;
      int    n;
      inf = lookup(op, fn);
      for (int i = 0; i <= fw; i++) begin
         e = '0; e.mem_req = 1'b1; e.ir_wr = (i == fw);
         exp_q.push_back(e); rdy_q.push_back(i == fw);
      end
      e = '0; e.state = 3'd1;
      ex_only = 1'b0;
      case (inf.cls)
         CL_J:   begin e.pc_wr = 1'b1; e.next_pc_sel = 2'b10; end
         CL_JR:  begin e.pc_wr = 1'b1; e.next_pc_sel = 2'b11; end
         CL_JAL: begin e.pc_wr = 1'b1; e.next_pc_sel = 2'b10; e.rf_wr = 1'b1;
                       e.dw_sel = 2'b01; e.rw_sel = 2'b10; end
         CL_ILL: begin e.pc_wr = 1'b1; e.illegal = 1'b1; end
         default: ex_only = 1'b1;
      endcase
      exp_q.push_back(e); rdy_q.push_back(1'($urandom));
      if (ex_only) begin
         e = '0; e.state = 3'd2; e.alu_op = inf.alu; e.alu_src_b = inf.srcb; e.seu_en = inf.seu;
         if (inf.cls == CL_BEQ || inf.cls == CL_BNE) begin
            e.pc_wr = 1'b1;
            e.next_pc_sel = ((inf.cls == CL_BEQ) == z) ? 2'b01 : 2'b00;
         end
         exp_q.push_back(e); rdy_q.push_back(1'($urandom));
         if (inf.cls == CL_LW || inf.cls == CL_SW) begin
            for (int i = 0; i <= mw; i++) begin
               e.state = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (inf.cls == CL_SW);
               e.pc_wr = (i == mw) && (inf.cls == CL_SW);
               exp_q.push_back(e); rdy_q.push_back(i == mw);
            end
         end
         if (inf.cls == CL_R || inf.cls == CL_I || inf.cls == CL_LW) begin
            e = '0; e.state = 3'd4; e.rf_wr = 1'b1; e.pc_wr = 1'b1;
            e.dw_sel = (inf.cls == CL_LW) ? 2'b10 : 2'b00;
            e.rw_sel = (inf.cls == CL_R) ? 2'b00 : 2'b01;
            exp_q.push_back(e); rdy_q.push_back(1'($urandom));
         end
      end
      opcode = op; funct = fn; zero = z;
      first_pc = 0; n_pc = 0; pc_nps = 2'b00; saw_ill = 1'b0; ex_alu = 4'b0000; n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         mem_ready = rdy_q.pop_front();
         n++;
         @(negedge clk);
         a = sample();
         chk("cycle_outputs", 32'(a), 32'(e));
         if (a.pc_wr) begin
            n_pc++;
            if (first_pc == 0) begin first_pc = n; pc_nps = a.next_pc_sel; end
         end
         if (a.illegal) saw_ill = 1'b1;
         if (a.state == 3'd2) ex_alu = a.alu_op;
         @(posedge clk); #1;
      end
      exp_retired++;
   endtask

   int         fp, np;
   logic [1:0] nps;
   logic       ill;
   logic [3:0] xalu;
   logic [5:0] rop, rfn;
   int         idx;

   initial begin
      itab[0]  = '{6'b000000, 6'b100000, CL_R, 4'b0000, 1'b0, 1'b0};
      itab[1]  = '{6'b000000, 6'b100001, CL_R, 4'b0000, 1'b0, 1'b0};
      itab[2]  = '{6'b000000, 6'b100010, CL_R, 4'b0001, 1'b0, 1'b0};
      itab[3]  = '{6'b000000, 6'b100011, CL_R, 4'b0001, 1'b0, 1'b0};
      itab[4]  = '{6'b000000, 6'b100100, CL_R, 4'b0010, 1'b0, 1'b0};
      itab[5]  = '{6'b000000, 6'b100101, CL_R, 4'b0011, 1'b0, 1'b0};
      itab[6]  = '{6'b000000, 6'b000000, CL_R, 4'b0100, 1'b0, 1'b0};
      itab[7]  = '{6'b000000, 6'b000010, CL_R, 4'b0101, 1'b0, 1'b0};
      itab[8]  = '{6'b000000, 6'b101010, CL_R, 4'b1000, 1'b0, 1'b0};
      itab[9]  = '{6'b000000, 6'b101011, CL_R, 4'b1000, 1'b0, 1'b0};
      itab[10] = '{6'b000000, 6'b001000, CL_JR, 4'b0000, 1'b0, 1'b0};
      itab[11] = '{6'b001000, 6'b000000, CL_I, 4'b0000, 1'b1, 1'b1};
      itab[12] = '{6'b001001, 6'b000000, CL_I, 4'b0000, 1'b1, 1'b0};
      itab[13] = '{6'b001100, 6'b000000, CL_I, 4'b0010, 1'b1, 1'b0};
      itab[14] = '{6'b001101, 6'b000000, CL_I, 4'b0011, 1'b1, 1'b0};
      itab[15] = '{6'b001010, 6'b000000, CL_I, 4'b1000, 1'b1, 1'b1};
      itab[16] = '{6'b001011, 6'b000000, CL_I, 4'b1000, 1'b1, 1'b0};
      itab[17] = '{6'b100011, 6'b000000, CL_LW, 4'b0000, 1'b1, 1'b1};
      itab[18] = '{6'b101011, 6'b000000, CL_SW, 4'b0000, 1'b1, 1'b1};
      itab[19] = '{6'b000100, 6'b000000, CL_BEQ, 4'b0000, 1'b0, 1'b1};
      itab[20] = '{6'b000101, 6'b000000, CL_BNE, 4'b0000, 1'b0, 1'b1};
      itab[21] = '{6'b000010, 6'b000000, CL_J, 4'b0000, 1'b0, 1'b0};
      itab[22] = '{6'b000011, 6'b000000, CL_JAL, 4'b0000, 1'b0, 1'b0};

      //          name        op         funct      z  fw mw cyc nps   ill  alu
      vt[0]  = '{"add",      6'b000000, 6'b100000, 0, 0, 0, 4, 2'b00, 0, 4'b0000};
      vt[1]  = '{"lw_wait2", 6'b100011, 6'b000000, 0, 0, 2, 7, 2'b00, 0, 4'b0000};
      vt[2]  = '{"sw",       6'b101011, 6'b010101, 0, 0, 0, 4, 2'b00, 0, 4'b0000};
      vt[3]  = '{"beq_tk",   6'b000100, 6'b000000, 1, 0, 0, 3, 2'b01, 0, 4'b0000};
      vt[4]  = '{"bne_nt",   6'b000101, 6'b000000, 1, 0, 0, 3, 2'b00, 0, 4'b0000};
      vt[5]  = '{"bne_tk",   6'b000101, 6'b000000, 0, 0, 0, 3, 2'b01, 0, 4'b0000};
      vt[6]  = '{"beq_nt",   6'b000100, 6'b000000, 0, 0, 0, 3, 2'b00, 0, 4'b0000};
      vt[7]  = '{"j",        6'b000010, 6'b000000, 0, 0, 0, 2, 2'b10, 0, 4'b0000};
      vt[8]  = '{"jr",       6'b000000, 6'b001000, 0, 0, 0, 2, 2'b11, 0, 4'b0000};
      vt[9]  = '{"jal",      6'b000011, 6'b000000, 0, 0, 0, 2, 2'b10, 0, 4'b0000};
      vt[10] = '{"ill_op",   6'b111111, 6'b000000, 0, 0, 0, 2, 2'b00, 1, 4'b0000};
      vt[11] = '{"sub_fw1",  6'b000000, 6'b100010, 0, 1, 0, 5, 2'b00, 0, 4'b0001};
      vt[12] = '{"ori",      6'b001101, 6'b000000, 0, 0, 0, 4, 2'b00, 0, 4'b0011};
      vt[13] = '{"sltiu",    6'b001011, 6'b000000, 0, 0, 0, 4, 2'b00, 0, 4'b1000};
      vt[14] = '{"sll",      6'b000000, 6'b000000, 0, 0, 0, 4, 2'b00, 0, 4'b0100};
      vt[15] = '{"ill_fn",   6'b000000, 6'b111111, 0, 0, 0, 2, 2'b00, 1, 4'b0000};
      vt[16] = '{"andi_fw2", 6'b001100, 6'b000000, 0, 2, 0, 6, 2'b00, 0, 4'b0010};
      vt[17] = '{"srl",      6'b000000, 6'b000010, 0, 0, 0, 4, 2'b00, 0, 4'b0101};

      rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'(sample()), 32'd0);
`ifdef INSTR_COUNT_EN
      chk("retired_reset", retired, 32'd0);
`endif
      rst = 1'b0;
      #1 chk("idle_before_first_edge", 32'(sample()), 32'd0);
      @(posedge clk); #1;

      foreach (vt[i]) begin
         run_instr(vt[i].op, vt[i].fn, vt[i].z, vt[i].fw, vt[i].mw, fp, np, nps, ill, xalu);
         chk({vt[i].name, "_cycles"}, 32'(fp), 32'(vt[i].cyc));
         chk({vt[i].name, "_pc_wr_once"}, 32'(np), 32'd1);
         chk({vt[i].name, "_next_pc_sel"}, 32'(nps), 32'(vt[i].nps));
         chk({vt[i].name, "_illegal"}, 32'(ill), 32'(vt[i].ill));
         chk({vt[i].name, "_exec_alu_op"}, 32'(xalu), 32'(vt[i].alu));
      end
`ifdef INSTR_COUNT_EN
      chk("retired_after_table", retired, 32'(exp_retired));
`endif

      // SW stalled in MEM, then reset: access aborts, no pc_wr
      opcode = 6'b101011; funct = 6'b000111; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1 mem_ready = 1'b0;
      @(negedge clk);
      chk("sw_mem_active", 32'({state, mem_req, mem_we, iord}), 32'({3'd3, 3'b111}));
      #2 rst = 1'b1;
      #1 chk("rst_mid_mem", 32'(sample()), 32'd0);
`ifdef INSTR_COUNT_EN
      chk("retired_after_rst", retired, 32'd0);
`endif
      exp_retired = 0;
      @(posedge clk); #1 mem_ready = 1'b1;
      @(negedge clk) chk("rst_held_mem_ready", 32'(sample()), 32'd0);
      rst = 1'b0;
      #1 chk("idle_after_release", 32'(sample()), 32'd0);
      @(posedge clk); #1;

      // Reset in the middle of a stalled FETCH: no ir_wr, clean restart
      opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b0;
      @(negedge clk);
      chk("fetch_stalled", 32'({state, mem_req, ir_wr}), 32'({3'd0, 2'b10}));
      #2 rst = 1'b1;
      #1 chk("rst_mid_fetch", 32'(sample()), 32'd0);
      @(posedge clk); #1 mem_ready = 1'b1;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, fp, np, nps, ill, xalu);
      chk("add_after_rst_cycles", 32'(fp), 32'd4);

      // Random instruction stream
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(9) == 0) begin
            rop = 6'($urandom); rfn = 6'($urandom);
         end else begin
            idx = $urandom_range(22);
            rop = itab[idx].op;
            rfn = (rop == 6'd0) ? itab[idx].fn : 6'($urandom);
         end
         run_instr(rop, rfn, 1'($urandom), $urandom_range(2), $urandom_range(2),
                   fp, np, nps, ill, xalu);
         chk("random_pc_wr_once", 32'(np), 32'd1);
      end
`ifdef INSTR_COUNT_EN
      chk("retired_final", retired, 32'(exp_retired));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
